apb_master_arbiter: RTL and testbench

//  Shares one downstream APB bus (NoApbSlaves select lines) between NoMasters APB requesters on apb_clk.

---
 rtl/apb_master_arbiter_pkg.sv | 29 ++
 rtl/apb_master_arbiter_rr_picker.sv | 29 ++
 rtl/apb_master_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_arbiter_pkg.sv
// Shared APB types and arbiter constants.
// Request/response bundles, arbiter FSM states, default timeout data.
package apb_master_arbiter_pkg;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_resp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam logic [31:0] APB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_master_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Ports: req (request vector), ptr (start index), valid, idx (winner).
module apb_rr_picker #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic            valid,
    output logic [IdxW-1:0] idx
);

    int j;

    // Walk from farthest to nearest so the nearest hit is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % int'(N);
            if (req[j]) begin
                valid = 1'b1;
                idx   = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB bus between several APB requesters.
// Ports: apb_clk/apb_rst, mst_reqs/mst_sels/mst_resps (upstream), apb_req/apb_sel/apb_resps (downstream), busy, timeout_evt.
module apb_master_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int unsigned NoMasters     = 2,
    parameter int unsigned NoApbSlaves   = 1,
    parameter int unsigned TimeoutCycles = 256,
    parameter logic [31:0] TimeoutData   = APB_TIMEOUT_DATA
) (
    input  logic                                  apb_clk,
    input  logic                                  apb_rst,
    input  apb_req_t  [NoMasters-1:0]             mst_reqs,
    input  logic      [NoMasters-1:0][NoApbSlaves-1:0] mst_sels,
    output apb_resp_t [NoMasters-1:0]             mst_resps,
    output apb_req_t                              apb_req,
    output logic      [NoApbSlaves-1:0]           apb_sel,
    input  apb_resp_t [NoApbSlaves-1:0]           apb_resps,
    output logic                                  busy,
    output logic                                  timeout_evt
);

    localparam int unsigned MstW = (NoMasters > 1) ? $clog2(NoMasters) : 1;
    localparam int unsigned SlvW = (NoApbSlaves > 1) ? $clog2(NoApbSlaves) : 1;
    localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

    arb_state_e            state_q, state_d;
    logic [MstW-1:0]       gnt_q, gnt_d;
    logic [MstW-1:0]       rr_q, rr_d;
    logic [SlvW-1:0]       slv_q, slv_d;
    apb_req_t              req_q, req_d;
    logic [NoApbSlaves-1:0] psel_q, psel_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  slverr_q, slverr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  tmo_q, tmo_d;
    logic                  busy_q, busy_d;

    logic [NoMasters-1:0]   pending;
    logic                   pick_valid;
    logic [MstW-1:0]        pick_idx;
    logic [NoApbSlaves-1:0] sel;
    logic                   sel_onehot;
    logic [SlvW-1:0]        sel_idx;

    always_comb begin
        pending = '0;
        for (int i = 0; i < int'(NoMasters); i++) begin
            pending[i] = (|mst_sels[i]) & mst_reqs[i].penable;
        end
    end

    apb_rr_picker #(
        .N    (NoMasters),
        .IdxW (MstW)
    ) u_picker (
        .req   (pending),
        .ptr   (rr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Slave select of the candidate master, one-hot check and encode.
    always_comb begin
        sel        = mst_sels[pick_idx];
        sel_onehot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
        sel_idx    = '0;
        for (int s = 0; s < int'(NoApbSlaves); s++) begin
            if (sel[s]) sel_idx = sel_idx | SlvW'(s);
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_d     = rr_q;
        slv_d    = slv_q;
        req_d    = req_q;
        psel_d   = psel_q;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;
        cnt_d    = cnt_q;
        tmo_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d         = pick_idx;
                    slv_d         = sel_idx;
                    req_d         = mst_reqs[pick_idx];
                    req_d.penable = 1'b0;
                    if (sel_onehot) begin
                        psel_d  = sel;
                        state_d = SETUP;
                    end else begin
                        // Ambiguous select: answer with an error, never touch the bus.
                        rdata_d  = TimeoutData;
                        slverr_d = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            SETUP: begin
                req_d.penable = 1'b1;
                state_d       = ACCESS;
            end
            ACCESS: begin
                if (apb_resps[slv_q].pready) begin
                    rdata_d       = apb_resps[slv_q].prdata;
                    slverr_d      = apb_resps[slv_q].pslverr;
                    psel_d        = '0;
                    req_d.penable = 1'b0;
                    cnt_d         = '0;
                    state_d       = RESP;
                end else if (TimeoutCycles != 0 && cnt_q == CntMax) begin
                    rdata_d       = TimeoutData;
                    slverr_d      = 1'b1;
                    tmo_d         = 1'b1;
                    psel_d        = '0;
                    req_d.penable = 1'b0;
                    cnt_d         = '0;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                rr_d    = (gnt_q == MstW'(NoMasters - 1)) ? '0 : gnt_q + 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge apb_clk or posedge apb_rst) begin
        if (apb_rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_q     <= '0;
            slv_q    <= '0;
            req_q    <= '0;
            psel_q   <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            slv_q    <= slv_d;
            req_q    <= req_d;
            psel_q   <= psel_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            busy_q   <= busy_d;
        end
    end

    assign apb_req     = req_q;
    assign apb_sel     = psel_q;
    assign busy        = busy_q;
    assign timeout_evt = tmo_q;

    // A master that abandoned its request gets no response.
    always_comb begin
        mst_resps = '0;
        if (state_q == RESP && pending[gnt_q]) begin
            mst_resps[gnt_q].pready  = 1'b1;
            mst_resps[gnt_q].prdata  = rdata_q;
            mst_resps[gnt_q].pslverr = slverr_q;
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed testbench for apb_master_arbiter.
// Two masters, two slaves, 8-cycle timeout.
module tb_apb_master_arbiter;
    import apb_master_arbiter_pkg::*;

    logic                  clk;
    logic                  rst;
    apb_req_t  [1:0]       mst_reqs;
    logic      [1:0][1:0]  mst_sels;
    apb_resp_t [1:0]       mst_resps;
    apb_req_t              apb_req;
    logic      [1:0]       apb_sel;
    apb_resp_t [1:0]       apb_resps;
    logic                  busy;
    logic                  timeout_evt;

    int vectors;
    int miscompares;

    apb_master_arbiter #(
        .NoMasters     (2),
        .NoApbSlaves   (2),
        .TimeoutCycles (8),
        .TimeoutData   (32'hDEAD_BEEF)
    ) dut (
        .apb_clk     (clk),
        .apb_rst     (rst),
        .mst_reqs    (mst_reqs),
        .mst_sels    (mst_sels),
        .mst_resps   (mst_resps),
        .apb_req     (apb_req),
        .apb_sel     (apb_sel),
        .apb_resps   (apb_resps),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic mreq(input int m, input logic [1:0] s, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
        mst_reqs[m].paddr   = a;
        mst_reqs[m].pprot   = 3'b000;
        mst_reqs[m].pwrite  = wr;
        mst_reqs[m].pwdata  = d;
        mst_reqs[m].pstrb   = 4'hF;
        mst_reqs[m].penable = 1'b1;
        mst_sels[m]         = s;
    endtask

    task automatic mdrop(input int m);
        mst_reqs[m] = '0;
        mst_sels[m] = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        mst_reqs    = '0;
        mst_sels    = '0;
        apb_resps   = '0;
        tick();
        tick();
        chk("rst_sel", 32'(apb_sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_penable", 32'(apb_req.penable), 32'h0);
        chk("rst_pready0", 32'(mst_resps[0].pready), 32'h0);
        rst = 1'b0;
        tick();

        // Single zero-wait write
        apb_resps[0].pready = 1'b1;
        mreq(0, 2'b01, 1'b1, 32'h0000_1004, 32'hA5A5_5A5A);
        tick();
        chk("w_setup_sel", 32'(apb_sel), 32'h1);
        chk("w_setup_pen", 32'(apb_req.penable), 32'h0);
        chk("w_setup_addr", apb_req.paddr, 32'h0000_1004);
        chk("w_setup_wr", 32'(apb_req.pwrite), 32'h1);
        chk("w_setup_busy", 32'(busy), 32'h1);
        tick();
        chk("w_acc_sel", 32'(apb_sel), 32'h1);
        chk("w_acc_pen", 32'(apb_req.penable), 32'h1);
        chk("w_acc_addr", apb_req.paddr, 32'h0000_1004);
        chk("w_acc_data", apb_req.pwdata, 32'hA5A5_5A5A);
        chk("w_acc_strb", 32'(apb_req.pstrb), 32'hF);
        tick();
        chk("w_resp_rdy", 32'(mst_resps[0].pready), 32'h1);
        chk("w_resp_err", 32'(mst_resps[0].pslverr), 32'h0);
        chk("w_resp_m1", 32'(mst_resps[1].pready), 32'h0);
        chk("w_resp_sel", 32'(apb_sel), 32'h0);
        mdrop(0);
        tick();
        chk("w_idle_busy", 32'(busy), 32'h0);

        // Two simultaneous reads, pointer at 0
        do_reset();
        mreq(0, 2'b01, 1'b0, 32'h0000_0100, 32'h0);
        mreq(1, 2'b01, 1'b0, 32'h0000_0200, 32'h0);
        apb_resps[0].prdata = 32'h11;
        tick();
        chk("rr_first_addr", apb_req.paddr, 32'h0000_0100);
        tick();
        tick();
        chk("rr_m0_rdy", 32'(mst_resps[0].pready), 32'h1);
        chk("rr_m0_data", mst_resps[0].prdata, 32'h11);
        chk("rr_m1_idle", 32'(mst_resps[1].pready), 32'h0);
        mdrop(0);
        apb_resps[0].prdata = 32'h22;
        tick();
        chk("rr_gap_busy", 32'(busy), 32'h0);
        tick();
        chk("rr_second_addr", apb_req.paddr, 32'h0000_0200);
        tick();
        tick();
        chk("rr_m1_rdy", 32'(mst_resps[1].pready), 32'h1);
        chk("rr_m1_data", mst_resps[1].prdata, 32'h22);
        chk("rr_m0_quiet", 32'(mst_resps[0].pready), 32'h0);
        mdrop(1);
        tick();
        mreq(0, 2'b01, 1'b0, 32'h0000_0100, 32'h0);
        mreq(1, 2'b01, 1'b0, 32'h0000_0200, 32'h0);
        tick();
        chk("rr_wrap_addr", apb_req.paddr, 32'h0000_0100);
        mdrop(0);
        mdrop(1);

        // Timeout on slave 1
        do_reset();
        apb_resps[1] = '0;
        mreq(0, 2'b10, 1'b1, 32'h0000_2000, 32'h5);
        tick();
        chk("to_setup_sel", 32'(apb_sel), 32'h2);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("to_acc_pen", 32'(apb_req.penable), 32'h1);
            chk("to_acc_evt", 32'(timeout_evt), 32'h0);
        end
        tick();
        chk("to_evt", 32'(timeout_evt), 32'h1);
        chk("to_rdy", 32'(mst_resps[0].pready), 32'h1);
        chk("to_err", 32'(mst_resps[0].pslverr), 32'h1);
        chk("to_data", mst_resps[0].prdata, 32'hDEAD_BEEF);
        chk("to_sel", 32'(apb_sel), 32'h0);
        mdrop(0);
        tick();
        chk("to_evt_once", 32'(timeout_evt), 32'h0);
        chk("to_idle_busy", 32'(busy), 32'h0);

        // pready on the last allowed ACCESS cycle
        apb_resps[1].prdata = 32'h1234;
        mreq(0, 2'b10, 1'b0, 32'h0000_2004, 32'h0);
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
        end
        chk("late_pen", 32'(apb_req.penable), 32'h1);
        apb_resps[1].pready = 1'b1;
        tick();
        chk("late_rdy", 32'(mst_resps[0].pready), 32'h1);
        chk("late_data", mst_resps[0].prdata, 32'h1234);
        chk("late_err", 32'(mst_resps[0].pslverr), 32'h0);
        chk("late_evt", 32'(timeout_evt), 32'h0);
        mdrop(0);
        apb_resps[1] = '0;
        tick();

        // Multi-hot select
        mreq(0, 2'b11, 1'b0, 32'h0000_3000, 32'h0);
        tick();
        chk("mh_sel", 32'(apb_sel), 32'h0);
        chk("mh_rdy", 32'(mst_resps[0].pready), 32'h1);
        chk("mh_err", 32'(mst_resps[0].pslverr), 32'h1);
        chk("mh_data", mst_resps[0].prdata, 32'hDEAD_BEEF);
        mdrop(0);
        tick();
        chk("mh_idle_busy", 32'(busy), 32'h0);

        // Reset during a waiting ACCESS
        apb_resps[0] = '0;
        mreq(1, 2'b01, 1'b1, 32'h0000_4000, 32'h77);
        tick();
        tick();
        chk("rm_acc_pen", 32'(apb_req.penable), 32'h1);
        rst = 1'b1;
        #1;
        chk("rm_sel", 32'(apb_sel), 32'h0);
        chk("rm_pen", 32'(apb_req.penable), 32'h0);
        chk("rm_busy", 32'(busy), 32'h0);
        chk("rm_no_resp", 32'(mst_resps[1].pready), 32'h0);
        mdrop(1);
        tick();
        rst = 1'b0;
        apb_resps[0].pready = 1'b1;
        apb_resps[0].prdata = 32'h55;
        mreq(1, 2'b01, 1'b0, 32'h0000_4008, 32'h0);
        tick();
        chk("rm_new_addr", apb_req.paddr, 32'h0000_4008);
        tick();
        tick();
        chk("rm_new_rdy", 32'(mst_resps[1].pready), 32'h1);
        chk("rm_new_data", mst_resps[1].prdata, 32'h55);
        mdrop(1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
